// File: rtl/hex_display_pkg.sv
// ============================================================================
// hex_display_pkg : shared types and segment constants for hex_display_ctrl
// Revision: 1.0
// ============================================================================
`default_nettype none

package hex_display_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CONVERT = 2'd1,
        DRIVE   = 2'd2,
        COMMIT  = 2'd3
    } state_t;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;

endpackage

`default_nettype wire

// File: rtl/seg7.sv
// ============================================================================
// seg7 : BCD to active-low seven-segment decoder, bit order gfedcba
// Revision: 1.0
// ============================================================================
`default_nettype none

module seg7 (
    input  logic [3:0] bcd,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'b1111111;
        case (bcd)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1111000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/hex_display_ctrl.sv
// ============================================================================
// hex_display_ctrl : binary to BCD (double-dabble) with time-shared seg7 drive
// Revision: 1.0
// ============================================================================
`default_nettype none

module hex_display_ctrl #(
    parameter int NUM_DIGITS = 6,
    parameter int BIN_W      = 20
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [BIN_W-1:0]        in_value,
    input  logic                    blank_lz,
    output logic                    busy,
    output logic                    overflow,
    output logic                    upd,
    output logic [7*NUM_DIGITS-1:0] hex_out
);

    import hex_display_pkg::*;

    localparam int          BCD_W   = 4 * NUM_DIGITS;
    localparam int          IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int          CNT_W   = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam logic [63:0] MAX_VAL = 64'(10 ** NUM_DIGITS - 1);

    function automatic logic [BCD_W-1:0] add3_all(input logic [BCD_W-1:0] b);
        logic [BCD_W-1:0] r;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            r[4*i +: 4] = (b[4*i +: 4] >= 4'd5) ? b[4*i +: 4] + 4'd3 : b[4*i +: 4];
        end
        return r;
    endfunction

    state_t           state;
    state_t           state_next;
    logic [BIN_W-1:0] shift_reg;
    logic [BCD_W-1:0] bcd;
    logic [BCD_W-1:0] bcd_adj;
    logic [CNT_W-1:0] bit_cnt;
    logic [IDX_W-1:0] idx;
    logic             lz;
    logic             ovf_pend;
    logic [6:0]       shadow [NUM_DIGITS];
    logic [3:0]       nib    [NUM_DIGITS];
    logic [3:0]       cur_nib;
    logic [6:0]       cur_seg;
    logic [6:0]       drive_seg;
    logic             upper_zero;
    logic             last_bit;
    logic             last_digit;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_nib
        assign nib[g] = bcd[4*g +: 4];
    end

    assign bcd_adj    = add3_all(bcd);
    assign last_bit   = (bit_cnt == CNT_W'(BIN_W - 1));
    assign last_digit = (idx == '0);
    assign cur_nib    = nib[idx];
    // Digit idx and every more-significant digit are zero.
    assign upper_zero = ((bcd >> (32'(idx) * 4)) == '0);

    seg7 u_seg7 (
        .bcd (cur_nib),
        .seg (cur_seg)
    );

    always_comb begin
        drive_seg = cur_seg;
        if (lz && (idx != '0) && upper_zero) drive_seg = SEG_BLANK;
        if (ovf_pend)                        drive_seg = SEG_DASH;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (in_valid)   state_next = CONVERT;
            CONVERT: if (last_bit)   state_next = DRIVE;
            DRIVE:   if (last_digit) state_next = COMMIT;
            COMMIT:                  state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == IDLE);
        busy     = (state != IDLE);
        upd      = (state == COMMIT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shift_reg <= '0;
            bcd       <= '0;
            bit_cnt   <= '0;
            idx       <= '0;
            lz        <= 1'b0;
            ovf_pend  <= 1'b0;
            overflow  <= 1'b0;
            hex_out   <= '1;
            for (int i = 0; i < NUM_DIGITS; i++) shadow[i] <= SEG_BLANK;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        shift_reg <= in_value;
                        lz        <= blank_lz;
                        ovf_pend  <= (64'(in_value) > MAX_VAL);
                        bcd       <= '0;
                        bit_cnt   <= '0;
                    end
                end
                CONVERT: begin
                    // Carry out of the top nibble only occurs above MAX_VAL, which is overridden.
                    {bcd, shift_reg} <= {bcd_adj[BCD_W-2:0], shift_reg, 1'b0};
                    if (last_bit) begin
                        bit_cnt <= '0;
                        idx     <= IDX_W'(NUM_DIGITS - 1);
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                DRIVE: begin
                    shadow[idx] <= drive_seg;
                    if (!last_digit) idx <= idx - 1'b1;
                end
                COMMIT: begin
                    for (int i = 0; i < NUM_DIGITS; i++) hex_out[7*i +: 7] <= shadow[i];
                    overflow <= ovf_pend;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
